// File: rtl/spi_controller.sv
// spi_controller: command-driven SPI master for a single memory that shares clk.
// A command is a two-cycle mode bit (wr), eight address bits and, for writes,
// eight data bits, all LSB-first on sdo while cs_n is low. Reads then wait for
// the memory's ready pulse and shift eight bits back in from sdi.
// Optional feature: define SPI_CTRL_TIMEOUT_EN to bound the ready/op_done waits
// by TIMEOUT_CYCLES clocks and flag the abandoned command with err.
module spi_controller #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       ready,
  input  logic       op_done,
  input  logic       sdi,
  output logic       cs_n,
  output logic       sdo,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    MODE,
    ADDR,
    WDATA,
    WAIT_RDY,
    RDATA,
    WAIT_DONE
  } state_t;

  state_t     state;
  logic       cmd_wr;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_din;
  logic [7:0] rx_shift;
  logic [3:0] bit_cnt;

  // A timeout shorter than one cycle cannot be counted, so such a build is rejected.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("spi_controller: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // The wait is abandoned on the edge that completes TIMEOUT_CYCLES idle cycles.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout feature the waits are unbounded and no error can occur.
  assign err = 1'b0;
`endif

  // Command sequencer: every output is registered so cs_n/sdo change only on clk edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      sdo      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= 8'h00;
      cmd_wr   <= 1'b0;
      cmd_addr <= 8'h00;
      cmd_din  <= 8'h00;
      rx_shift <= 8'h00;
      bit_cnt  <= 4'd0;
`ifdef SPI_CTRL_TIMEOUT_EN
      tmo_cnt  <= '0;
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SPI_CTRL_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (newd) begin
            cmd_wr   <= wr;
            cmd_addr <= addr;
            cmd_din  <= din;
            cs_n     <= 1'b0;
            sdo      <= wr;
            busy     <= 1'b1;
            bit_cnt  <= 4'd0;
            state    <= MODE;
          end
        end
        MODE: begin
          sdo     <= cmd_wr;
          bit_cnt <= 4'd0;
          state   <= ADDR;
        end
        ADDR: begin
          if (bit_cnt == 4'd8) begin
            cs_n    <= 1'b1;
            sdo     <= 1'b0;
            bit_cnt <= 4'd0;
`ifdef SPI_CTRL_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state   <= WAIT_RDY;
          end else begin
            sdo <= cmd_addr[bit_cnt[2:0]];
            if (bit_cnt == 4'd7 && cmd_wr) begin
              bit_cnt <= 4'd0;
              state   <= WDATA;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        WDATA: begin
          if (bit_cnt == 4'd8) begin
            cs_n    <= 1'b1;
            sdo     <= 1'b0;
            bit_cnt <= 4'd0;
`ifdef SPI_CTRL_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state   <= WAIT_DONE;
          end else begin
            sdo     <= cmd_din[bit_cnt[2:0]];
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        WAIT_RDY: begin
          if (ready) begin
            bit_cnt <= 4'd0;
            state   <= RDATA;
          end
`ifdef SPI_CTRL_TIMEOUT_EN
          else if (tmo_hit) begin
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RDATA: begin
          rx_shift <= {sdi, rx_shift[7:1]};
          if (bit_cnt == 4'd7) begin
            bit_cnt <= 4'd0;
`ifdef SPI_CTRL_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state   <= WAIT_DONE;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (op_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            if (!cmd_wr) begin
              dout <= rx_shift;
            end
          end
`ifdef SPI_CTRL_TIMEOUT_EN
          else if (tmo_hit) begin
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        default: begin
          cs_n  <= 1'b1;
          sdo   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed bench for spi_controller with a behavioural SPI
// memory attached. A cycle-level model derived from the command framing and the
// nominal latencies predicts every output on every cycle; directed scenarios add
// hand-computed literal checks. Honours SPI_CTRL_TIMEOUT_EN like the design.
module tb_spi_controller;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst, newd, wr, ready, op_done, sdi;
  logic [7:0] addr, din;
  logic       cs_n, sdo, busy, done, err;
  logic [7:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .newd(newd), .wr(wr), .addr(addr), .din(din),
    .ready(ready), .op_done(op_done), .sdi(sdi),
    .cs_n(cs_n), .sdo(sdo), .dout(dout), .busy(busy), .done(done), .err(err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural memory: collects each cs_n-low frame, then answers on its own timing.
  logic [7:0]  mem [256];
  bit          mem_reply_en = 1'b1;
  int          fr_n = 0;
  logic [17:0] fr_bits = '0;
  int          rd_phase = 0;
  logic [7:0]  rd_byte = '0;

  always @(posedge clk) begin
    logic cs_s, sdo_s;
    cs_s  = cs_n;
    sdo_s = sdo;
    #1;
    if (mem_reply_en) begin
      ready = 1'b0; op_done = 1'b0; sdi = 1'b0;
    end
    if (rd_phase > 0) begin
      if (mem_reply_en) begin
        if (rd_phase <= 8) sdi = rd_byte[rd_phase-1];
        else op_done = 1'b1;
      end
      rd_phase = (rd_phase >= 9) ? 0 : rd_phase + 1;
    end
    if (!cs_s) begin
      if (fr_n < 18) fr_bits[fr_n] = sdo_s;
      fr_n++;
    end else if (fr_n > 0) begin
      if (fr_bits[0] && fr_n == 18) begin
        mem[fr_bits[9:2]] = fr_bits[17:10];
        if (mem_reply_en) op_done = 1'b1;
      end else if (!fr_bits[0] && fr_n == 10) begin
        rd_byte  = mem[fr_bits[9:2]];
        rd_phase = 1;
        if (mem_reply_en) ready = 1'b1;
      end
      fr_n = 0;
    end
  end

  // Reference model: position t within the command frame decides every output.
  bit         m_active = 1'b0, m_done = 1'b0, m_err = 1'b0, m_tmo = 1'b0;
  int         m_t = 0, m_done_t = 0;
  logic       m_wr = 1'b0;
  logic [7:0] m_addr = '0, m_din = '0, m_dout = '0;
  logic [7:0] m_mem [256];

  always @(posedge clk) begin
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_dout   = 8'h00;
    end else if (m_active) begin
      m_t++;
      if (m_t == m_done_t) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_err    = m_tmo;
        if (!m_tmo) begin
          if (m_wr) m_mem[m_addr] = m_din;
          else      m_dout = m_mem[m_addr];
        end
      end
    end else if (newd) begin
      m_active = 1'b1;
      m_t = 0; m_wr = wr; m_addr = addr; m_din = din;
      if (mem_reply_en) begin
        m_done_t = wr ? 20 : 21;
        m_tmo    = 1'b0;
      end else begin
`ifdef SPI_CTRL_TIMEOUT_EN
        m_done_t = (wr ? 18 : 10) + TMO;
        m_tmo    = 1'b1;
`else
        m_done_t = 1_000_000;
        m_tmo    = 1'b0;
`endif
      end
    end
  end

  function automatic logic frame_bit(input int t);
    if (t < 2)       return m_wr;
    else if (t < 10) return m_addr[t-2];
    else             return m_din[t-10];
  endfunction

  // Per-cycle comparison of every output against the model, half a cycle after the edge.
  always @(negedge clk) begin
    logic e_low, e_sdo;
    e_low = m_active && (m_t <= (m_wr ? 17 : 9));
    e_sdo = e_low ? frame_bit(m_t) : 1'b0;
    checkOutput("cs_n",  cs_n, !e_low);
    checkOutput("sdo",   sdo,  e_sdo);
    checkOutput("busy",  busy, m_active);
    checkOutput("done",  done, m_done);
    checkOutput("err",   err,  m_err);
    checkOutput("dout",  dout, m_dout);
  end

  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d);
    newd = 1'b1; wr = w; addr = a; din = d;
    @(negedge clk);
    newd = 1'b0;
  endtask

  task automatic runCommand(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input int max_n, input int inj_n,
                            output int cs_low, output int cs_falls, output int done_at,
                            output int done_pulses, output logic [31:0] sdo_tr,
                            output logic [7:0] dout_d, output logic err_d);
    logic prev_cs;
    prev_cs = 1'b1;
    cs_low = 0; cs_falls = 0; done_at = -1; done_pulses = 0;
    sdo_tr = '0; dout_d = '0; err_d = 1'b0;
    applyStimulus(w, a, d);
    for (int n = 0; n < max_n; n++) begin
      if (n == inj_n) begin
        newd = 1'b1; wr = 1'b1; addr = 8'h07; din = 8'hC3;
      end else if (n == inj_n + 1) begin
        newd = 1'b0;
      end
      if (!cs_n) cs_low++;
      if (prev_cs && !cs_n) cs_falls++;
      prev_cs = cs_n;
      if (n < 32) sdo_tr[n] = sdo;
      if (done) begin
        done_pulses++;
        if (done_at < 0) begin
          done_at = n; dout_d = dout; err_d = err;
        end
      end
      @(negedge clk);
    end
  endtask

  int          cs_low, cs_falls, done_at, done_pulses, cnt_a, cnt_b;
  logic [31:0] sdo_tr;
  logic [7:0]  dout_d;
  logic        err_d;
  logic [17:0] exp_sdo_w = 18'b10100101_000000_1111;
  logic [9:0]  exp_sdo_r = 10'b00000_01100;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i * 7 + 1);
      m_mem[i] = 8'(i * 7 + 1);
    end
    rst = 1'b1; newd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    ready = 1'b0; op_done = 1'b0; sdi = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("reset cs_n", cs_n, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset dout", dout, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] write 0x03 <= 0xA5");
    runCommand(1'b1, 8'h03, 8'hA5, 26, -1, cs_low, cs_falls, done_at, done_pulses, sdo_tr, dout_d, err_d);
    checkOutput("write sdo frame", sdo_tr[17:0], exp_sdo_w);
    checkOutput("write cs_n low cycles", cs_low, 18);
    checkOutput("write done cycle", done_at, 20);
    checkOutput("write err", err_d, 1'b0);
    checkOutput("write done pulses", done_pulses, 1);
    checkOutput("write keeps dout", dout, 8'h00);

    $display("[TB] read 0x03");
    runCommand(1'b0, 8'h03, 8'h00, 26, -1, cs_low, cs_falls, done_at, done_pulses, sdo_tr, dout_d, err_d);
    checkOutput("read sdo frame", sdo_tr[9:0], exp_sdo_r);
    checkOutput("read cs_n low cycles", cs_low, 10);
    checkOutput("read done cycle", done_at, 21);
    checkOutput("read dout", dout_d, 8'hA5);
    checkOutput("read err", err_d, 1'b0);

    $display("[TB] write 0x07 <= 0x3C then read back");
    runCommand(1'b1, 8'h07, 8'h3C, 26, -1, cs_low, cs_falls, done_at, done_pulses, sdo_tr, dout_d, err_d);
    checkOutput("second write holds dout", dout, 8'hA5);
    runCommand(1'b0, 8'h07, 8'h00, 26, -1, cs_low, cs_falls, done_at, done_pulses, sdo_tr, dout_d, err_d);
    checkOutput("read 0x07 dout", dout_d, 8'h3C);

    $display("[TB] newd held high across completion");
    cnt_a = 0; cnt_b = 0;
    newd = 1'b1; wr = 1'b1; addr = 8'h10; din = 8'h99;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) cnt_a++;
      if (done && !cs_n) cnt_b++;
      if (n == 24) newd = 1'b0;
    end
    checkOutput("held newd done pulses", cnt_a, 2);
    checkOutput("done with cs_n low", cnt_b, 0);

    $display("[TB] busy rejection during read");
    runCommand(1'b0, 8'h03, 8'h00, 30, 5, cs_low, cs_falls, done_at, done_pulses, sdo_tr, dout_d, err_d);
    checkOutput("busy reject cs_n assertions", cs_falls, 1);
    checkOutput("busy reject done pulses", done_pulses, 1);
    checkOutput("busy reject read dout", dout_d, 8'hA5);

    $display("[TB] reset abort of a write");
    applyStimulus(1'b1, 8'h03, 8'h5A);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort cs_n", cs_n, 1'b1);
    checkOutput("abort busy", busy, 1'b0);
    rst = 1'b0;
    runCommand(1'b0, 8'h03, 8'h00, 26, -1, cs_low, cs_falls, done_at, done_pulses, sdo_tr, dout_d, err_d);
    checkOutput("post-abort done cycle", done_at, 21);
    checkOutput("post-abort done pulses", done_pulses, 1);
    checkOutput("post-abort read dout", dout_d, 8'hA5);

    $display("[TB] stray ready/op_done while idle");
    mem_reply_en = 1'b0;
    ready = 1'b1; op_done = 1'b1;
    @(negedge clk);
    ready = 1'b0; op_done = 1'b0;
    @(negedge clk);
    checkOutput("stray pulse done", done, 1'b0);
    checkOutput("stray pulse busy", busy, 1'b0);

`ifdef SPI_CTRL_TIMEOUT_EN
    $display("[TB] read timeout with ready tied low");
    runCommand(1'b0, 8'h03, 8'h00, 90, -1, cs_low, cs_falls, done_at, done_pulses, sdo_tr, dout_d, err_d);
    checkOutput("timeout done cycle", done_at, 10 + TMO);
    checkOutput("timeout err", err_d, 1'b1);
    checkOutput("timeout dout unchanged", dout_d, 8'hA5);
    checkOutput("timeout done pulses", done_pulses, 1);
`else
    $display("[TB] read with ready tied low waits indefinitely");
    cnt_a = 0; cnt_b = 0;
    applyStimulus(1'b0, 8'h03, 8'h00);
    for (int n = 0; n < 500; n++) begin
      if (busy) cnt_a++;
      if (done) cnt_b++;
      @(negedge clk);
    end
    checkOutput("no-timeout busy cycles", cnt_a, 500);
    checkOutput("no-timeout done pulses", cnt_b, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("recover busy", busy, 1'b0);
`endif

    $display("[TB] final read of 0x10");
    mem_reply_en = 1'b1;
    @(negedge clk);
    runCommand(1'b0, 8'h10, 8'h00, 26, -1, cs_low, cs_falls, done_at, done_pulses, sdo_tr, dout_d, err_d);
    checkOutput("final read dout", dout_d, 8'h99);
    checkOutput("final read done cycle", done_at, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
